// File: rtl/dmem_pkg.sv
// Shared types for the load/store data memory: access size encoding and
// the controller state. Imported by data_memory_ls and dmem_align.
package dmem_pkg;

  // Access size; the encoding value is log2 of the byte count.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } dmem_size_e;

  // CLEAR zeroes the array after reset; READY serves requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for data_memory_ls: store byte enables and shifted
// store word, misalignment detection for both ports, and load extraction
// with sign/zero extension. Purely combinational.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int N = 64,
  localparam int BYTES = N / 8,
  localparam int OFF_W = $clog2(N / 8)
) (
  input  logic [1:0]       wr_size,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [N-1:0]     wr_data,
  output logic [BYTES-1:0] wr_be,
  output logic [N-1:0]     wr_word,
  output logic             wr_mis,
  input  logic [1:0]       rd_size,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_mis,
  input  logic [2:0]       ld_size,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [N-1:0]     ld_word,
  output logic [N-1:0]     ld_data
);

  // Offset is widened to 3 bits so the same checks work for 4- and 8-byte words.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [2:0] o;
    o = 3'(off);
    case (dmem_size_e'(sz))
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = o[0];
      SZ_W:    is_misaligned = |o[1:0];
      default: is_misaligned = (N == 32) ? 1'b1 : |o;
    endcase
  endfunction

  assign wr_mis  = is_misaligned(wr_size, wr_off);
  assign rd_mis  = is_misaligned(rd_size, rd_off);
  assign wr_word = wr_data << {wr_off, 3'b000};

  // A lane is enabled when it falls inside [off, off + size_bytes).
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_be
      assign wr_be[gi] = (gi >= int'(wr_off)) && (gi < int'(wr_off) + (1 << wr_size));
    end
  endgenerate

  logic [63:0] ld_sh;
  logic [63:0] ld_ext;
  logic        ld_sx;

  // Right-justify the addressed bytes, then extend to 64 bits and trim to N.
  always_comb begin
    ld_sh  = 64'(ld_word >> {ld_off, 3'b000});
    ld_sx  = ~ld_size[2];
    ld_ext = ld_sh;
    case (dmem_size_e'(ld_size[1:0]))
      SZ_B:    ld_ext = {{56{ld_sx & ld_sh[7]}},  ld_sh[7:0]};
      SZ_H:    ld_ext = {{48{ld_sx & ld_sh[15]}}, ld_sh[15:0]};
      SZ_W:    ld_ext = {{32{ld_sx & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
    ld_data = ld_ext[N-1:0];
  end

endmodule

// File: rtl/data_memory_ls.sv
// Byte-addressable little-endian data memory with B/H/W/D loads and stores,
// one read and one write port per cycle, and a self-clearing start-up phase.
// Optional macro DMEM_FWD_EN: a same-cycle read and write to the same word
// returns the write-merged data; without it the read sees pre-write contents.
module data_memory_ls
  import dmem_pkg::*;
#(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [2:0]              rd_size,
  input  logic [1:0]              wr_size,
  input  logic [ADDRESS_SIZE-1:0] rd_addr,
  input  logic [ADDRESS_SIZE-1:0] wr_addr,
  input  logic [N-1:0]            data_in,
  output logic [N-1:0]            data_out,
  output logic                    rd_valid,
  output logic                    misaligned,
  output logic                    busy
);

  localparam int BYTES = N / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = ADDRESS_SIZE - OFF_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

  dmem_state_e      state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;

  logic             ready;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [OFF_W-1:0] rd_off, wr_off;
  logic [BYTES-1:0] wr_be;
  logic [N-1:0]     wr_word;
  logic             wr_mis, rd_mis;
  logic             rd_fire, wr_fire;

  logic             ram_we;
  logic [IDX_W-1:0] ram_widx;
  logic [BYTES-1:0] ram_be;
  logic [N-1:0]     ram_wdata;
  logic [N-1:0]     ram_q;

  logic             rd_valid_reg, mis_reg, have_data_reg;
  logic [2:0]       ld_size_reg;
  logic [OFF_W-1:0] ld_off_reg;
  logic [N-1:0]     ld_data;

  assign ready   = (state_reg == ST_READY);
  assign busy    = (state_reg == ST_CLEAR);
  assign rd_idx  = rd_addr[ADDRESS_SIZE-1:OFF_W];
  assign wr_idx  = wr_addr[ADDRESS_SIZE-1:OFF_W];
  assign rd_off  = rd_addr[OFF_W-1:0];
  assign wr_off  = wr_addr[OFF_W-1:0];
  assign rd_fire = ready & mem_read & ~rd_mis;
  assign wr_fire = ready & mem_write & ~wr_mis;

  dmem_align #(.N(N)) u_align (
    .wr_size (wr_size),
    .wr_off  (wr_off),
    .wr_data (data_in),
    .wr_be   (wr_be),
    .wr_word (wr_word),
    .wr_mis  (wr_mis),
    .rd_size (rd_size[1:0]),
    .rd_off  (rd_off),
    .rd_mis  (rd_mis),
    .ld_size (ld_size_reg),
    .ld_off  (ld_off_reg),
    .ld_word (ram_q),
    .ld_data (ld_data)
  );

  // The single write port is shared: the clear sweep owns it until READY.
  // Held off while in reset so reset alone never alters stored contents.
  assign ram_we    = rst & (~ready | wr_fire);
  assign ram_widx  = ready ? wr_idx  : cnt_reg;
  assign ram_be    = ready ? wr_be   : '1;
  assign ram_wdata = ready ? wr_word : '0;

  // Controller state and clear counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Sweep one word per cycle in CLEAR; READY is terminal until reset.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end
      end
      default: ;
    endcase
  end

  // Response flags and the load attributes needed to extract the next data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg  <= 1'b0;
      mis_reg       <= 1'b0;
      have_data_reg <= 1'b0;
      ld_size_reg   <= '0;
      ld_off_reg    <= '0;
    end else begin
      rd_valid_reg <= rd_fire;
      mis_reg      <= ready & ((mem_read & rd_mis) | (mem_write & wr_mis));
      if (rd_fire) begin
        have_data_reg <= 1'b1;
        ld_size_reg   <= rd_size;
        ld_off_reg    <= rd_off;
      end
    end
  end

  // One byte-wide RAM per lane so byte enables map onto plain write enables.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] q_lane_reg;

      // Read-first lane RAM; output register only advances on an accepted read.
      always_ff @(posedge clk) begin
        if (ram_we && ram_be[gi]) mem_lane[ram_widx] <= ram_wdata[8*gi +: 8];
        if (rd_fire) q_lane_reg <= mem_lane[rd_idx];
      end

`ifdef DMEM_FWD_EN
      logic       fwd_hit_reg;
      logic [7:0] fwd_byte_reg;

      // Capture a same-word write to this lane so it overrides the stale RAM byte.
      always_ff @(posedge clk) begin
        if (rd_fire) begin
          fwd_hit_reg  <= wr_fire && (wr_idx == rd_idx) && wr_be[gi];
          fwd_byte_reg <= wr_word[8*gi +: 8];
        end
      end

      assign ram_q[8*gi +: 8] = fwd_hit_reg ? fwd_byte_reg : q_lane_reg;
`else
      assign ram_q[8*gi +: 8] = q_lane_reg;
`endif
    end
  endgenerate

  assign data_out   = have_data_reg ? ld_data : '0;
  assign rd_valid   = rd_valid_reg;
  assign misaligned = mis_reg;

endmodule

// File: tb/tb_data_memory_ls.sv
// Self-checking bench for data_memory_ls (N=64, ADDRESS_SIZE=10): directed
// scenarios followed by randomized traffic against a byte-array reference.
module tb_data_memory_ls;

  localparam int AS = 10;
  localparam int NW = 64;

`ifdef DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [2:0]    rd_size = 3'd0;
  logic [1:0]    wr_size = 2'd0;
  logic [AS-1:0] rd_addr = '0;
  logic [AS-1:0] wr_addr = '0;
  logic [NW-1:0] data_in = '0;
  logic [NW-1:0] data_out;
  logic          rd_valid, misaligned, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mdl_mem [1 << AS];
  logic [63:0] exp_dout = 64'h0;

  always #5 clk = ~clk;

  data_memory_ls #(.ADDRESS_SIZE(AS), .N(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .rd_size    (rd_size),
    .wr_size    (wr_size),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .misaligned (misaligned),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [AS-1:0] a);
    return (int'(a) % (1 << sz)) != 0;
  endfunction

  function automatic logic [AS-1:0] align_addr(input logic [AS-1:0] a, input logic [1:0] sz);
    return AS'((int'(a) / (1 << sz)) * (1 << sz));
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < (1 << AS); i++) mdl_mem[i] = 8'h00;
  endtask

  task automatic mdl_store(input logic [AS-1:0] a, input logic [1:0] sz, input logic [63:0] d);
    for (int i = 0; i < (1 << sz); i++) mdl_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  // Little-endian gather of the addressed bytes, then sign or zero fill.
  function automatic logic [63:0] mdl_load(input logic [AS-1:0] a, input logic [2:0] sz);
    int          nb;
    logic [63:0] v;
    nb = 1 << sz[1:0];
    v  = 64'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl_mem[int'(a) + i];
    if (nb < 8 && !sz[2] && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One request cycle: drive, predict, clock, compare all three outputs.
  task automatic step(input logic rd, input logic wr, input logic [2:0] rsz, input logic [1:0] wsz,
                      input logic [AS-1:0] ra, input logic [AS-1:0] wa, input logic [63:0] din);
    bit rmis, wmis, rok, wok;
    mem_read  = rd;
    mem_write = wr;
    rd_size   = rsz;
    wr_size   = wsz;
    rd_addr   = ra;
    wr_addr   = wa;
    data_in   = din;
    rmis = rd && is_mis(rsz[1:0], ra);
    wmis = wr && is_mis(wsz, wa);
    rok  = rd && !rmis;
    wok  = wr && !wmis;
    if (FWD && wok) mdl_store(wa, wsz, din);
    if (rok) exp_dout = mdl_load(ra, rsz);
    if (!FWD && wok) mdl_store(wa, wsz, din);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check_eq("rd_valid", 64'(rd_valid), 64'(rok));
    check_eq("misaligned", 64'(misaligned), 64'(rmis || wmis));
    check_eq("data_out", data_out, exp_dout);
    $display("txn rd=%0b rsz=%0d ra=%h wr=%0b wsz=%0d wa=%h din=%h -> rv=%0b mis=%0b dout=%h",
             rd, rsz, ra, wr, wsz, wa, din, rd_valid, misaligned, data_out);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 2'd0, '0, '0, 64'h0);
  endtask

  // Count busy cycles; optionally hammer the ports, which must stay silent.
  task automatic clear_phase(input bit poke, output int n);
    n = 0;
    while (busy && n < 1000) begin
      if (poke) begin
        mem_read  = 1'b1;
        mem_write = 1'b1;
        rd_size   = 3'($urandom_range(0, 7));
        wr_size   = 2'($urandom_range(0, 3));
        rd_addr   = AS'($urandom);
        wr_addr   = AS'($urandom);
        data_in   = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      n++;
      if (poke) begin
        check_eq("clr_rd_valid", 64'(rd_valid), 64'h0);
        check_eq("clr_mis", 64'(misaligned), 64'h0);
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    $display("txn clear busy_cycles=%0d", n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0]    rsz;
    logic [1:0]    wsz;
    logic [AS-1:0] ra, wa;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'h1);
    check_eq("rst_dout", data_out, 64'h0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'h0);
    check_eq("rst_mis", 64'(misaligned), 64'h0);

    // Initial clear sweep takes exactly DEPTH = 128 cycles.
    rst = 1'b1;
    clear_phase(1'b0, n);
    check_eq("clear_cycles", 64'(n), 64'd128);
    check_eq("busy_after_clear", 64'(busy), 64'h0);
    mdl_clear();

    // Load from cleared memory, then rd_valid drops again.
    step(1'b1, 1'b0, 3'd3, 2'd0, 10'h040, '0, 64'h0);
    check_eq("ld040_const", data_out, 64'h0);
    idle();

    // Doubleword store and loads of several sizes.
    step(1'b0, 1'b1, 3'd0, 2'd3, '0, 10'h068, 64'h0123456789ABCDEF);
    step(1'b1, 1'b0, 3'd3, 2'd0, 10'h068, '0, 64'h0);
    check_eq("ld068_const", data_out, 64'h0123456789ABCDEF);
    step(1'b1, 1'b0, 3'd0, 2'd0, 10'h068, '0, 64'h0);
    check_eq("lb068_const", data_out, 64'hFFFFFFFFFFFFFFEF);
    step(1'b1, 1'b0, 3'd4, 2'd0, 10'h068, '0, 64'h0);
    check_eq("lbu068_const", data_out, 64'h00000000000000EF);

    // Halfword store merges into the stored word.
    step(1'b0, 1'b1, 3'd0, 2'd1, '0, 10'h06A, 64'h000000000000BEEF);
    step(1'b1, 1'b0, 3'd3, 2'd0, 10'h068, '0, 64'h0);
    check_eq("sh_merge_const", data_out, 64'h01234567BEEFCDEF);

    // Misaligned store is dropped; misaligned load gives no rd_valid.
    step(1'b0, 1'b1, 3'd0, 2'd2, '0, 10'h06A, 64'h00000000DEADBEEF);
    check_eq("sw_mis_const", 64'(misaligned), 64'h1);
    step(1'b1, 1'b0, 3'd3, 2'd0, 10'h068, '0, 64'h0);
    check_eq("sw_unchanged_const", data_out, 64'h01234567BEEFCDEF);
    step(1'b1, 1'b0, 3'd1, 2'd0, 10'h069, '0, 64'h0);
    check_eq("lh_mis_const", 64'(misaligned), 64'h1);
    check_eq("lh_no_valid_const", 64'(rd_valid), 64'h0);

    // Same-cycle read and write to one word.
    step(1'b1, 1'b1, 3'd3, 2'd3, 10'h070, 10'h070, 64'h0000000000001111);
    check_eq("fwd_const", data_out, FWD ? 64'h1111 : 64'h0);

    // Both ports misaligned together: one pulse only.
    step(1'b1, 1'b1, 3'd1, 2'd2, 10'h071, 10'h072, 64'h55);
    idle();
    check_eq("mis_single_pulse", 64'(misaligned), 64'h0);

    // Randomized traffic over a small window so reads and writes collide often.
    for (int t = 0; t < 300; t++) begin
      rsz = 3'($urandom_range(0, 7));
      wsz = 2'($urandom_range(0, 3));
      ra  = AS'($urandom_range(0, 127));
      wa  = AS'($urandom_range(0, 127));
      if ($urandom_range(0, 4) != 0) ra = align_addr(ra, rsz[1:0]);
      if ($urandom_range(0, 4) != 0) wa = align_addr(wa, wsz);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsz, wsz, ra, wa,
           {$urandom, $urandom});
    end

    // Seed first and last words, then reset in the middle of a clear.
    step(1'b0, 1'b1, 3'd0, 2'd3, '0, 10'h000, 64'hA5A5A5A5A5A5A5A5);
    step(1'b0, 1'b1, 3'd0, 2'd3, '0, 10'h3F8, 64'h5A5A5A5A5A5A5A5A);
    rst = 1'b0;
    #1;
    exp_dout = 64'h0;
    check_eq("rst2_dout", data_out, 64'h0);
    check_eq("rst2_busy", 64'(busy), 64'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check_eq("clr50_busy", 64'(busy), 64'h1);
    rst = 1'b0;
    #1;
    check_eq("midclr_rst_busy", 64'(busy), 64'h1);
    check_eq("midclr_rst_rd_valid", 64'(rd_valid), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_phase(1'b1, n);
    check_eq("reclear_cycles", 64'(n), 64'd128);
    mdl_clear();
    step(1'b1, 1'b0, 3'd3, 2'd0, 10'h000, '0, 64'h0);
    check_eq("word0_cleared", data_out, 64'h0);
    step(1'b1, 1'b0, 3'd3, 2'd0, 10'h3F8, '0, 64'h0);
    check_eq("wordlast_cleared", data_out, 64'h0);
    step(1'b1, 1'b0, 3'd3, 2'd0, 10'h068, '0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ls.md
DATA_MEMORY_LS -- requirements
Module: data_memory_ls

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 10, byte-address width.
REQ-002 SHALL have parameter N, default 64, data/word width; legal values 32 or 64.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_read  input  1  read request.
REQ-006 SHALL have port mem_write  input  1  write request.
REQ-007 SHALL have port rd_size  input  3  bits [1:0] size (B/H/W/D), bit [2] unsigned load.
REQ-008 SHALL have port wr_size  input  2  store size (B/H/W/D).
REQ-009 SHALL have port rd_addr  input  ADDRESS_SIZE  read byte address.
REQ-010 SHALL have port wr_addr  input  ADDRESS_SIZE  write byte address.
REQ-011 SHALL have port data_in  input  N  store data, right-justified.
REQ-012 SHALL have port data_out  output  N  load data, extended to N.
REQ-013 SHALL have port rd_valid  output  1  data_out valid, one-cycle pulse per accepted read.
REQ-014 SHALL have port misaligned  output  1  one-cycle pulse, rejected access.
REQ-015 SHALL have port busy  output  1  initialisation clear in progress.

Function
REQ-016 SHALL store DEPTH = 2^ADDRESS_SIZE / (N/8) words, little-endian; word index = addr >> log2(N/8).
REQ-017 SHALL accept requests only in READY; requests in CLEAR are ignored with no output response.
REQ-018 SHALL write only the bytes selected by wr_size and wr_addr low bits, at the rising edge of the request cycle.
REQ-019 SHALL present a load on data_out with rd_valid=1 exactly one cycle after the mem_read cycle; data_out holds its value until the next accepted read.
REQ-020 SHALL sign-extend loads when rd_size[2]=0 and zero-extend when rd_size[2]=1; D ignores rd_size[2].
REQ-021 SHALL flag an access as misaligned when the address is not a multiple of its size, or when size D is requested with N=32.
REQ-022 SHALL suppress a misaligned write (memory unchanged), suppress rd_valid for a misaligned read, and pulse misaligned one cycle later; a simultaneous read and write both misaligned still produce one pulse.
REQ-023 SHALL allow a read and a write in the same cycle to any addresses.
REQ-024 SHALL implement FSM states CLEAR and READY: CLEAR writes zero to word counter 0..DEPTH-1, one word per cycle, busy=1; CLEAR->READY after word DEPTH-1; READY persists until reset.

Reset
REQ-025 SHALL, while rst=0, force data_out=0, rd_valid=0, misaligned=0, busy=1, counter=0, state=CLEAR.
REQ-026 SHALL restart CLEAR from word 0 when reset asserts mid-clear; memory contents are not otherwise reset.

Configuration
REQ-027 SHALL, with DMEM_FWD_EN defined, return write-first data for a same-cycle read and write to the same word (written bytes merged with stored bytes).
REQ-028 SHALL, without DMEM_FWD_EN, return the pre-write stored contents in that case.

Structure
REQ-029 SHALL place the size enumeration (SZ_B, SZ_H, SZ_W, SZ_D) and FSM state typedef in package dmem_pkg.
REQ-030 SHALL implement byte-enable/shift generation, load extraction/extension and misalignment detection in sub-module dmem_align.

Verification (N=64, ADDRESS_SIZE=10)
REQ-031 SHALL check: release rst -> busy=1 exactly 128 cycles, then 0; LD 0x040 -> data_out=0, rd_valid one cycle later.
REQ-032 SHALL check: SD 0x0123456789ABCDEF @0x068; LD 0x068 -> 0x0123456789ABCDEF; LB 0x068 -> 0xFFFFFFFFFFFFFFEF; LBU 0x068 -> 0x00000000000000EF.
REQ-033 SHALL check: SH 0xBEEF @0x06A after REQ-032 -> LD 0x068 returns 0x01234567BEEFCDEF.
REQ-034 SHALL check: SW @0x06A -> misaligned=1 next cycle, LD 0x068 unchanged; LH 0x069 -> misaligned=1, rd_valid=0.
REQ-035 SHALL check: same-cycle SD 0x1111 @0x070 and LD 0x070 (old 0) -> data_out=0x1111 with DMEM_FWD_EN, 0 without.
REQ-036 SHALL check: assert rst at clear cycle 50 -> busy stays 1, full 128-cycle clear restarts after release; requests during clear produce no rd_valid.
